playback_ctrl: RTL

PLAYBACK_CTRL -- requirements
Module: playback_ctrl

---
 rtl/playback_ctrl_pkg.sv | 19 +
 rtl/playback_ctrl_beat_timer.sv | 42 ++++
 rtl/playback_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/playback_ctrl_pkg.sv
// Shared types and constants for the playback sequencer.
package playback_ctrl_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_PLAY  = 1'b1
    } state_t;

    localparam int unsigned MODE_W = 2;
    localparam logic [MODE_W-1:0] MODE_STOP     = 2'd0;
    localparam logic [MODE_W-1:0] MODE_REPEAT   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_ADVANCE  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_ADV_STOP = 2'd3;

    localparam int unsigned STEP_W = 3;
    localparam logic [STEP_W-1:0] STEP_NORMAL = 3'd1;
    localparam logic [STEP_W-1:0] STEP_FF     = 3'd4;

endpackage

// File: rtl/playback_ctrl_beat_timer.sv
// Beat divider: counts clk cycles by a variable step and pulses beat on wrap.
module beat_timer
    import playback_ctrl_pkg::*;
#(
    parameter int unsigned BEAT_COUNT = 1250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [STEP_W-1:0] step,
    input  logic              clear,
    output logic              beat,
    output logic              wrap_c,
    output logic              active_c
);

    localparam int unsigned CNT_W = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;

    logic [CNT_W-1:0] count;
    logic [31:0]      sum;

    // Wide sum so a fast-forward step past the terminal count still wraps cleanly.
    assign sum      = 32'(count) + 32'(step);
    assign wrap_c   = (sum >= 32'(BEAT_COUNT));
    assign active_c = (count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            beat  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            beat  <= 1'b0;
        end else if (enable) begin
            count <= wrap_c ? '0 : CNT_W'(sum);
            beat  <= wrap_c;
        end else begin
            beat  <= 1'b0;
        end
    end

endmodule

// File: rtl/playback_ctrl.sv
// Song/note playback sequencer with pause, next/prev and end-of-song policy.
// Optional fast-forward input ff is built when PLAYBACK_CTRL_FF_EN is defined.
module playback_ctrl
    import playback_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SONGS   = 4,
    parameter int unsigned NOTE_ADDR_W = 5,
    parameter int unsigned BEAT_COUNT  = 1250000,
    parameter int unsigned DUR_W       = 6,
    localparam int unsigned SONG_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   play_button,
    input  logic                   next_button,
    input  logic                   prev_button,
    input  logic [MODE_W-1:0]      mode,
    input  logic [DUR_W-1:0]       note_duration,
    input  logic                   note_last,
`ifdef PLAYBACK_CTRL_FF_EN
    input  logic                   ff,
`endif
    output logic [SONG_W-1:0]      song,
    output logic [NOTE_ADDR_W-1:0] note_addr,
    output logic                   playing,
    output logic                   note_valid,
    output logic                   beat,
    output logic                   song_done
);

    state_t                 state, state_nxt;
    logic                   playing_nxt;
    logic [SONG_W-1:0]      song_nxt;
    logic [NOTE_ADDR_W-1:0] addr_nxt;
    logic [DUR_W-1:0]       dur_q, dur_q_nxt;
    logic                   last_q, last_nxt;
    logic [DUR_W-1:0]       dur_cnt, dur_cnt_nxt;
    logic                   song_done_nxt;
    logic                   note_valid_nxt;

    logic                   timer_en, timer_clr;
    logic [STEP_W-1:0]      step;
    logic                   wrap_c, active_c;

    logic                   btn_next, btn_prev, btn_play, run;
    logic                   play_go, fetch_go, last_beat, note_end, restart;
    logic [DUR_W-1:0]       dur_eff;
    logic [SONG_W-1:0]      song_inc, song_dec;
    logic                   song_at_last;

`ifdef PLAYBACK_CTRL_FF_EN
    assign step = ff ? STEP_FF : STEP_NORMAL;
`else
    assign step = STEP_NORMAL;
`endif

    // Button priority next > prev > play; any accepted button replaces advancement.
    assign btn_next = next_button;
    assign btn_prev = prev_button & ~next_button;
    assign btn_play = play_button & ~next_button & ~prev_button;
    assign run      = playing & ~btn_next & ~btn_prev & ~btn_play;
    assign fetch_go = run & (state == ST_FETCH);
    assign play_go  = run & (state == ST_PLAY);

    assign dur_eff   = (dur_q == '0) ? DUR_W'(1) : dur_q;
    assign last_beat = (dur_cnt == (dur_eff - DUR_W'(1)));
    assign note_end  = play_go & wrap_c & last_beat;
    assign restart   = (note_addr != '0) | active_c | (dur_cnt != '0);

    assign song_at_last = (song == SONG_W'(NUM_SONGS - 1));
    assign song_inc     = song_at_last ? '0 : song + SONG_W'(1);
    assign song_dec     = (song == '0) ? SONG_W'(NUM_SONGS - 1) : song - SONG_W'(1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_FETCH;
            playing    <= 1'b0;
            song       <= '0;
            note_addr  <= '0;
            dur_q      <= '0;
            last_q     <= 1'b0;
            dur_cnt    <= '0;
            song_done  <= 1'b0;
            note_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            playing    <= playing_nxt;
            song       <= song_nxt;
            note_addr  <= addr_nxt;
            dur_q      <= dur_q_nxt;
            last_q     <= last_nxt;
            dur_cnt    <= dur_cnt_nxt;
            song_done  <= song_done_nxt;
            note_valid <= note_valid_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt   = state;
        playing_nxt = playing;
        song_nxt    = song;
        addr_nxt    = note_addr;
        dur_q_nxt   = dur_q;
        last_nxt    = last_q;
        dur_cnt_nxt = dur_cnt;

        if (btn_next) begin
            song_nxt    = song_inc;
            addr_nxt    = '0;
            state_nxt   = ST_FETCH;
            playing_nxt = 1'b0;
            dur_cnt_nxt = '0;
        end else if (btn_prev) begin
            if (!restart) begin
                song_nxt = song_dec;
            end
            addr_nxt    = '0;
            state_nxt   = ST_FETCH;
            playing_nxt = 1'b0;
            dur_cnt_nxt = '0;
        end else if (btn_play) begin
            playing_nxt = ~playing;
        end else if (playing) begin
            if (state == ST_FETCH) begin
                dur_q_nxt   = note_duration;
                last_nxt    = note_last;
                dur_cnt_nxt = '0;
                state_nxt   = ST_PLAY;
            end else if (wrap_c) begin
                if (last_beat) begin
                    state_nxt   = ST_FETCH;
                    dur_cnt_nxt = '0;
                    if (!last_q) begin
                        addr_nxt = note_addr + NOTE_ADDR_W'(1);
                    end else begin
                        addr_nxt = '0;
                        case (mode)
                            MODE_STOP:    playing_nxt = 1'b0;
                            MODE_REPEAT:  song_nxt = song;
                            MODE_ADVANCE: song_nxt = song_inc;
                            default: begin
                                song_nxt = song_inc;
                                if (song_at_last) begin
                                    playing_nxt = 1'b0;
                                end
                            end
                        endcase
                    end
                end else begin
                    dur_cnt_nxt = dur_cnt + DUR_W'(1);
                end
            end
        end
    end

    // Output and timer-control logic
    always_comb begin
        song_done_nxt  = 1'b0;
        note_valid_nxt = 1'b0;
        timer_en       = 1'b0;
        timer_clr      = 1'b0;

        song_done_nxt  = note_end & last_q;
        note_valid_nxt = playing_nxt & (state_nxt == ST_PLAY);
        timer_en       = play_go;
        timer_clr      = fetch_go | btn_next | btn_prev;
    end

    beat_timer #(
        .BEAT_COUNT(BEAT_COUNT)
    ) u_beat_timer (
        .clk      (clk),
        .reset    (reset),
        .enable   (timer_en),
        .step     (step),
        .clear    (timer_clr),
        .beat     (beat),
        .wrap_c   (wrap_c),
        .active_c (active_c)
    );

endmodule
